// File: rtl/ce_tick_scheduler.sv
// rtl/ce_tick_scheduler.sv - runtime-programmable multi-channel clock-enable scheduler
// Divides the base tick into P_CH periodic one-cycle enables; live divide changes land on period boundaries.
module ce_tick_scheduler #(
  parameter int P_CH          = 4,
  parameter int P_WIDTH       = 16,
  parameter int P_DEFAULT_DIV = 1000,
  localparam int CHW          = $clog2(P_CH) | 1
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_CE,
  input  logic               I_SYNC,
  input  logic               I_CFG_VALID,
  output logic               O_CFG_READY,
  input  logic [CHW-1:0]     I_CFG_CH,
  input  logic [P_WIDTH-1:0] I_CFG_DIV,
  input  logic               I_CFG_EN,
  output logic [P_CH-1:0]    O_CE
);

  logic [P_WIDTH-1:0] cnt_q [P_CH];
  logic [P_WIDTH-1:0] cnt_d [P_CH];
  logic [P_WIDTH-1:0] div_q [P_CH];
  logic [P_WIDTH-1:0] div_d [P_CH];
  logic [P_WIDTH-1:0] last_cnt [P_CH];
  logic [P_CH-1:0]    en_q, en_d;
  logic [P_CH-1:0]    ce_q, ce_d;
  logic [P_CH-1:0]    wrap;
  logic               pend_q, pend_d;
  logic [CHW-1:0]     pend_ch_q, pend_ch_d;
  logic [P_WIDTH-1:0] pend_div_q, pend_div_d;
  logic               accept;

  assign accept      = I_CFG_VALID & ~pend_q;
  assign O_CFG_READY = ~pend_q;
  assign O_CE        = ce_q;

  // A divide of 0 behaves as 1, so the terminal count is 0 in both cases.
  always_comb begin
    wrap = '0;
    for (int ch = 0; ch < P_CH; ch++) begin
      last_cnt[ch] = (div_q[ch] == '0) ? '0 : div_q[ch] - P_WIDTH'(1);
      wrap[ch]     = en_q[ch] & I_CE & ~I_SYNC & (cnt_q[ch] == last_cnt[ch]);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    en_d       = en_q;
    ce_d       = '0;
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    for (int ch = 0; ch < P_CH; ch++) begin
      if (I_SYNC || !en_q[ch] || wrap[ch]) begin
        cnt_d[ch] = '0;
      end else if (I_CE) begin
        cnt_d[ch] = cnt_q[ch] + P_WIDTH'(1);
      end
      ce_d[ch] = wrap[ch];
      // The wrap that retires a pending divide still pulses with the old one.
      if (pend_q && (pend_ch_q == CHW'(ch)) && (I_SYNC || wrap[ch])) begin
        div_d[ch] = pend_div_q;
        en_d[ch]  = 1'b1;
        pend_d    = 1'b0;
      end
      // Out-of-range channel indices match no iteration and are silently dropped.
      if (accept && (I_CFG_CH == CHW'(ch))) begin
        if (!en_q[ch] || !I_CFG_EN) begin
          div_d[ch] = I_CFG_DIV;
          en_d[ch]  = I_CFG_EN;
          cnt_d[ch] = '0;
          ce_d[ch]  = 1'b0;
        end else begin
          pend_d     = 1'b1;
          pend_ch_d  = I_CFG_CH;
          pend_div_d = I_CFG_DIV;
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      for (int ch = 0; ch < P_CH; ch++) begin
        cnt_q[ch] <= '0;
        div_q[ch] <= P_WIDTH'(P_DEFAULT_DIV);
      end
      en_q       <= '0;
      ce_q       <= '0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      en_q       <= en_d;
      ce_q       <= ce_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
    end
  end

endmodule

// File: tb/tb_ce_tick_scheduler.sv
// tb/tb_ce_tick_scheduler.sv - self-checking bench for ce_tick_scheduler
// Directed scenarios plus a randomized run against a tick-counting reference model.
module tb_ce_tick_scheduler;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_en;
  logic [3:0]  o_ce;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: ticks elapsed in the current period per channel
  int         m_ph  [4];
  int         m_div [4];
  bit         m_en  [4];
  bit         m_pend;
  int         m_pch;
  int         m_pdiv;
  logic [3:0] m_ce;
  logic       m_rdy;

  ce_tick_scheduler #(.P_CH(4), .P_WIDTH(16), .P_DEFAULT_DIV(1000)) dut (
    .I_CLK      (clk),
    .I_RST_N    (rst_n),
    .I_CE       (ce),
    .I_SYNC     (sync),
    .I_CFG_VALID(cfg_valid),
    .O_CFG_READY(cfg_ready),
    .I_CFG_CH   (cfg_ch),
    .I_CFG_DIV  (cfg_div),
    .I_CFG_EN   (cfg_en),
    .O_CE       (o_ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ph[i] = 0; m_div[i] = 1000; m_en[i] = 0;
    end
    m_pend = 0; m_pch = 0; m_pdiv = 0; m_ce = '0; m_rdy = 1'b1;
  endtask

  task automatic model_step();
    bit wrapped [4];
    bit rdy_now;
    int c;
    rdy_now = !m_pend;
    for (int i = 0; i < 4; i++) begin
      wrapped[i] = 0;
      m_ce[i] = 1'b0;
      if (sync || !m_en[i]) m_ph[i] = 0;
      else if (ce) begin
        m_ph[i]++;
        if (m_ph[i] == eff(m_div[i])) begin
          m_ph[i] = 0; m_ce[i] = 1'b1; wrapped[i] = 1;
        end
      end
    end
    if (m_pend && (sync || wrapped[m_pch])) begin
      m_div[m_pch] = m_pdiv; m_en[m_pch] = 1; m_ph[m_pch] = 0; m_pend = 0;
    end
    if (cfg_valid && rdy_now && cfg_ch < 3'd4) begin
      c = int'(cfg_ch);
      if (!m_en[c] || !cfg_en) begin
        m_div[c] = int'(cfg_div); m_en[c] = cfg_en; m_ph[c] = 0; m_ce[c] = 1'b0;
      end else begin
        m_pend = 1; m_pch = c; m_pdiv = int'(cfg_div);
      end
    end
    m_rdy = !m_pend;
  endtask

  task automatic drive_cycle(input logic t_ce, input logic t_sync, input logic t_v,
                             input logic [2:0] t_ch, input logic [15:0] t_div, input logic t_en);
    ce = t_ce; sync = t_sync; cfg_valid = t_v; cfg_ch = t_ch; cfg_div = t_div; cfg_en = t_en;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ce = 0; sync = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; cfg_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_ce !== 4'b0 || cfg_ready !== 1'b1)
      $display("FAIL reset_state: got ce=%b ready=%b want ce=0000 ready=1", o_ce, cfg_ready);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== 4'b0) $display("FAIL reset_disabled: got %b want 0000", o_ce);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive_cycle(0, 0, 1, 3'd0, 16'd3, 1);
    for (int k = 1; k <= 12; k++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== {3'b0, (k % 3 == 0)})
        $display("FAIL basic_tick k=%0d: got %b want %b", k, o_ce, {3'b0, (k % 3 == 0)});
      else n_pass++;
      for (int j = 0; j < 3; j++) begin
        drive_cycle(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (o_ce !== 4'b0) $display("FAIL basic_idle k=%0d: got %b want 0000", k, o_ce);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reconfig();
    logic exp_p;
    logic exp_r;
    do_reset();
    drive_cycle(0, 0, 1, 3'd0, 16'd3, 1);
    for (int k = 1; k <= 13; k++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      exp_p = (k == 3) || (k > 3 && (k - 3) % 5 == 0);
      exp_r = (k == 1) || (k >= 3);
      n_checks++;
      if (o_ce[0] !== exp_p || cfg_ready !== exp_r)
        $display("FAIL reconfig k=%0d: got ce0=%b rdy=%b want ce0=%b rdy=%b", k, o_ce[0], cfg_ready, exp_p, exp_r);
      else n_pass++;
      if (k == 1) begin
        drive_cycle(0, 0, 1, 3'd0, 16'd5, 1);
        n_checks++;
        if (cfg_ready !== 1'b0) $display("FAIL reconfig_ready: got %b want 0", cfg_ready);
        else n_pass++;
        drive_cycle(0, 0, 0, 0, 0, 0);
      end else begin
        drive_cycle(0, 0, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_div0();
    logic t;
    do_reset();
    drive_cycle(0, 0, 1, 3'd2, 16'd0, 1);
    for (int i = 0; i < 20; i++) begin
      t = ($urandom_range(0, 1) == 1);
      drive_cycle(t, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== {1'b0, t, 2'b00}) $display("FAIL div0 i=%0d: got %b want %b", i, o_ce, {1'b0, t, 2'b00});
      else n_pass++;
    end
  endtask

  task automatic test_sync();
    do_reset();
    drive_cycle(0, 0, 1, 3'd0, 16'd7, 1);
    repeat (3) drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 3'd1, 16'd9, 1);
    repeat (5) drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (o_ce !== 4'b0) $display("FAIL sync_priority: got %b want 0000", o_ce);
    else n_pass++;
    for (int k = 1; k <= 63; k++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== {2'b00, (k % 9 == 0), (k % 7 == 0)})
        $display("FAIL sync_phase k=%0d: got %b want %b", k, o_ce, {2'b00, (k % 9 == 0), (k % 7 == 0)});
      else n_pass++;
      drive_cycle(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_disable_and_bad_ch();
    bit found;
    do_reset();
    drive_cycle(0, 0, 1, 3'd1, 16'd4, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_ph[1] == 3) begin
        found = 1;
        drive_cycle(1, 0, 1, 3'd1, 16'd4, 0);
        n_checks++;
        if (o_ce[1] !== 1'b0) $display("FAIL disable_wrap: got %b want 0", o_ce[1]);
        else n_pass++;
      end else begin
        drive_cycle(1, 0, 0, 0, 0, 0);
      end
    end
    n_checks++;
    if (!found) $display("FAIL disable_search: got no wrap cycle want one within 20");
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== 4'b0) $display("FAIL disabled_quiet: got %b want 0000", o_ce);
      else n_pass++;
    end
    drive_cycle(0, 0, 1, 3'd0, 16'd2, 1);
    drive_cycle(1, 0, 1, 3'd5, 16'd1, 1);
    n_checks++;
    if (cfg_ready !== 1'b1 || o_ce !== m_ce)
      $display("FAIL bad_ch: got rdy=%b ce=%b want rdy=1 ce=%b", cfg_ready, o_ce, m_ce);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== {3'b0, (i % 2 == 0)}) $display("FAIL bad_ch_after i=%0d: got %b want %b", i, o_ce, {3'b0, (i % 2 == 0)});
      else n_pass++;
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    drive_cycle(0, 0, 1, 3'd0, 16'd50, 1);
    drive_cycle(0, 0, 1, 3'd1, 16'd3, 1);
    drive_cycle(0, 0, 1, 3'd0, 16'd5, 1);
    repeat (3) drive_cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (o_ce !== 4'b0010 || cfg_ready !== 1'b0)
      $display("FAIL pre_reset: got ce=%b rdy=%b want ce=0010 rdy=0", o_ce, cfg_ready);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_ce !== 4'b0 || cfg_ready !== 1'b1)
      $display("FAIL async_reset: got ce=%b rdy=%b want ce=0000 rdy=1", o_ce, cfg_ready);
    else n_pass++;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (o_ce !== 4'b0) $display("FAIL post_reset i=%0d: got %b want 0000", i, o_ce);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic r_ce, r_sync, r_v, r_en;
    logic [2:0] r_ch;
    logic [15:0] r_div;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_ce   = ($urandom_range(0, 2) == 0);
      r_sync = ($urandom_range(0, 60) == 0);
      r_v    = ($urandom_range(0, 3) == 0);
      r_ch   = 3'($urandom_range(0, 5));
      r_div  = 16'($urandom_range(0, 6));
      r_en   = ($urandom_range(0, 4) != 0);
      drive_cycle(r_ce, r_sync, r_v, r_ch, r_div, r_en);
      n_checks++;
      if (o_ce !== m_ce || cfg_ready !== m_rdy)
        $display("FAIL random i=%0d: got ce=%b rdy=%b want ce=%b rdy=%b", i, o_ce, cfg_ready, m_ce, m_rdy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reconfig();
    test_div0();
    test_sync();
    test_disable_and_bad_ch();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
